// File: rtl/powlib_edge.sv
// -----------------------------------------------------------------------------
// powlib_edge -- registered per-bit edge detector
//
// Purpose:
//   Keeps the last accepted sample of `in` (prv) and flags, per bit, a rising
//   (0->1) and/or falling (1->0) transition between that sample and the new
//   one. The flags are registered and last one cycle unless a further edge is
//   accepted.
//
// Parameters:
//   W    : data width (>= 1)
//   INIT : reset value of the sampled-history register
//   EAR  : must be 0; any other value stops elaboration
//   EHN  : 1 enables falling-edge detection
//   EHP  : 1 enables rising-edge detection
//   EVLD : 1 samples only while vld=1; 0 samples every cycle
//
// Ports:
//   clk  : clock, all state updates on its rising edge
//   rst  : synchronous active-low reset
//   vld  : input qualifier, only meaningful when EVLD=1
//   in   : monitored data, W bits
//   out  : registered per-bit edge flags, W bits
//   any  : registered OR of the edge flags (only with POWLIB_EDGE_ANY_EN)
//
// Configuration:
//   `define POWLIB_EDGE_ANY_EN adds the `any` output.
// -----------------------------------------------------------------------------
module powlib_edge #(
   parameter int             W    = 1,
   parameter logic [W-1:0]   INIT = '0,
   parameter int             EAR  = 0,
   parameter int             EHN  = 0,
   parameter int             EHP  = 1,
   parameter int             EVLD = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld,
   input  logic [W-1:0]  in,
`ifdef POWLIB_EDGE_ANY_EN
   output logic [W-1:0]  out,
   output logic          any
`else
   output logic [W-1:0]  out
`endif
);

   // Unsupported configurations are rejected at elaboration time.
   if (EAR != 0) begin : g_ear_check
      $error("powlib_edge: EAR=%0d is not supported, only 0", EAR);
   end
   if (W < 1) begin : g_w_check
      $error("powlib_edge: W=%0d is illegal, must be >= 1", W);
   end

   // Replicated enables so the edge equation is a plain bitwise expression.
   localparam logic [W-1:0] EHP_MASK = (EHP != 0) ? {W{1'b1}} : {W{1'b0}};
   localparam logic [W-1:0] EHN_MASK = (EHN != 0) ? {W{1'b1}} : {W{1'b0}};

   logic [W-1:0] prv_q, prv_d;
   logic [W-1:0] out_q, out_d;
   logic         accept;

   // A sample is taken every cycle, or only when qualified by vld.
   assign accept = (EVLD == 0) || vld;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      prv_d = prv_q;
      out_d = '0;
      if (accept) begin
         prv_d = in;
         out_d = (EHP_MASK & in & ~prv_q) | (EHN_MASK & ~in & prv_q);
      end
   end

   // Reset is synchronous and takes priority over sampling; it also drops
   // whatever edge would otherwise have been flagged this cycle.
   // NOTE: registers use non-blocking assignments so every flop sees the
   // pre-edge values of the others, matching real hardware.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prv_q <= INIT;
         out_q <= '0;
      end else begin
         prv_q <= prv_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

`ifdef POWLIB_EDGE_ANY_EN
   // `any` is registered alongside `out` so both change on the same edge.
   logic any_q, any_d;

   always_comb begin
      any_d = |out_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         any_q <= 1'b0;
      end else begin
         any_q <= any_d;
      end
   end

   assign any = any_q;
`endif

endmodule

// File: tb/tb_powlib_edge.sv
// -----------------------------------------------------------------------------
// tb_powlib_edge -- self-checking bench for powlib_edge
//
// Five instances with different configurations share clock and reset:
//   u0 : W=13, rising only, INIT=0
//   u1 : W=7,  falling only, INIT=7'h2A
//   u2 : W=7,  rising and falling
//   u3 : W=7,  rising only, vld-gated
//   u4 : W=5,  no edge types enabled (constant zero)
// A stimulus process drives inputs, computes the expected outputs from a
// per-bit transition model and queues them; a monitor process pops one entry
// after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_powlib_edge;

   localparam int N = 5;

   typedef struct packed {
      logic [N-1:0][12:0] out;
      logic [N-1:0]       any;
   } exp_t;

   // Per-instance configuration used by the reference model.
   int           w_p    [N] = '{13, 7, 7, 7, 5};
   bit           ehp_p  [N] = '{1, 0, 1, 1, 0};
   bit           ehn_p  [N] = '{0, 1, 1, 0, 0};
   bit           evld_p [N] = '{0, 0, 0, 1, 0};
   logic [12:0]  init_p [N] = '{13'h0000, 13'h002A, 13'h0000, 13'h0000, 13'h0000};

   logic               clk = 1'b0;
   logic               rst_s;
   logic [N-1:0][12:0] in_v;
   logic [N-1:0]       vld_v;
   logic [N-1:0][12:0] out_all;
   logic [N-1:0]       any_all;

   logic [12:0] out0;
   logic [6:0]  out1, out2, out3;
   logic [4:0]  out4;

   exp_t        sb_q [$];
   logic [12:0] prv_m [N];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   bit          stim_done = 1'b0;

   always #5 clk = ~clk;

`ifdef POWLIB_EDGE_ANY_EN
   powlib_edge #(.W(13), .INIT(13'h0000), .EAR(0), .EHN(0), .EHP(1), .EVLD(0)) u0 (
      .clk(clk), .rst(rst_s), .vld(vld_v[0]), .in(in_v[0][12:0]), .out(out0), .any(any_all[0]));
   powlib_edge #(.W(7), .INIT(7'h2A), .EAR(0), .EHN(1), .EHP(0), .EVLD(0)) u1 (
      .clk(clk), .rst(rst_s), .vld(vld_v[1]), .in(in_v[1][6:0]), .out(out1), .any(any_all[1]));
   powlib_edge #(.W(7), .INIT(7'h00), .EAR(0), .EHN(1), .EHP(1), .EVLD(0)) u2 (
      .clk(clk), .rst(rst_s), .vld(vld_v[2]), .in(in_v[2][6:0]), .out(out2), .any(any_all[2]));
   powlib_edge #(.W(7), .INIT(7'h00), .EAR(0), .EHN(0), .EHP(1), .EVLD(1)) u3 (
      .clk(clk), .rst(rst_s), .vld(vld_v[3]), .in(in_v[3][6:0]), .out(out3), .any(any_all[3]));
   powlib_edge #(.W(5), .INIT(5'h00), .EAR(0), .EHN(0), .EHP(0), .EVLD(0)) u4 (
      .clk(clk), .rst(rst_s), .vld(vld_v[4]), .in(in_v[4][4:0]), .out(out4), .any(any_all[4]));
`else
   powlib_edge #(.W(13), .INIT(13'h0000), .EAR(0), .EHN(0), .EHP(1), .EVLD(0)) u0 (
      .clk(clk), .rst(rst_s), .vld(vld_v[0]), .in(in_v[0][12:0]), .out(out0));
   powlib_edge #(.W(7), .INIT(7'h2A), .EAR(0), .EHN(1), .EHP(0), .EVLD(0)) u1 (
      .clk(clk), .rst(rst_s), .vld(vld_v[1]), .in(in_v[1][6:0]), .out(out1));
   powlib_edge #(.W(7), .INIT(7'h00), .EAR(0), .EHN(1), .EHP(1), .EVLD(0)) u2 (
      .clk(clk), .rst(rst_s), .vld(vld_v[2]), .in(in_v[2][6:0]), .out(out2));
   powlib_edge #(.W(7), .INIT(7'h00), .EAR(0), .EHN(0), .EHP(1), .EVLD(1)) u3 (
      .clk(clk), .rst(rst_s), .vld(vld_v[3]), .in(in_v[3][6:0]), .out(out3));
   powlib_edge #(.W(5), .INIT(5'h00), .EAR(0), .EHN(0), .EHP(0), .EVLD(0)) u4 (
      .clk(clk), .rst(rst_s), .vld(vld_v[4]), .in(in_v[4][4:0]), .out(out4));
   assign any_all = '0;
`endif

   assign out_all[0] = out0;
   assign out_all[1] = {6'b0, out1};
   assign out_all[2] = {6'b0, out2};
   assign out_all[3] = {6'b0, out3};
   assign out_all[4] = {8'b0, out4};

   // ---------------------------------------------------------------- checker
   task automatic check(input string name, input int d, input logic [12:0] got,
                        input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s u%0d cycle %0d: got %h, expected %h", name, d, cyc, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Decides each bit from the previous accepted sample: a bit that changed
   // is flagged when its direction is one of the enabled edge types.
   task automatic model_step(input logic r, input logic [N-1:0][12:0] ins,
                             input logic [N-1:0] v, output exp_t e);
      e = '0;
      for (int d = 0; d < N; d++) begin
         if (!r) begin
            prv_m[d] = init_p[d];
         end else if (!evld_p[d] || v[d]) begin
            for (int i = 0; i < w_p[d]; i++) begin
               if (ins[d][i] != prv_m[d][i]) begin
                  if (ins[d][i] == 1'b1 && ehp_p[d]) e.out[d][i] = 1'b1;
                  if (ins[d][i] == 1'b0 && ehn_p[d]) e.out[d][i] = 1'b1;
               end
               prv_m[d][i] = ins[d][i];
            end
         end
         e.any[d] = |e.out[d];
      end
   endtask

   // Applies one cycle of stimulus and queues the result expected after the
   // coming rising edge.
   task automatic drive(input logic r, input logic [N-1:0][12:0] ins,
                        input logic [N-1:0] v);
      exp_t e;
      rst_s = r;
      in_v  = ins;
      vld_v = v;
      model_step(r, ins, v, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0][12:0] bcast(input logic [12:0] val);
      logic [N-1:0][12:0] r;
      for (int d = 0; d < N; d++) r[d] = val;
      return r;
   endfunction

   // ---------------------------------------------------------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int d = 0; d < N; d++) begin
               check("out", d, out_all[d], e.out[d]);
`ifdef POWLIB_EDGE_ANY_EN
               check("any", d, {12'b0, any_all[d]}, {12'b0, e.any[d]});
`endif
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [N-1:0][12:0] ins;
      logic [N-1:0]       v;
      logic               r;

      rst_s = 1'b0;
      in_v  = '0;
      vld_v = '1;
      for (int d = 0; d < N; d++) prv_m[d] = 13'h0;
      #1;

      // Reset state, with inputs that would otherwise flag edges.
      drive(1'b0, bcast(13'h1FFF), 5'h1F);
      drive(1'b0, bcast(13'h0000), 5'h00);

      // Rising-only small pattern, then a bit dropping (ignored by u0).
      drive(1'b1, bcast(13'h0005), 5'h1F);
      drive(1'b1, bcast(13'h0005), 5'h1F);
      drive(1'b1, bcast(13'h0004), 5'h1F);

      // Falling edges on the upper bits.
      drive(1'b1, bcast(13'h007F), 5'h1F);
      drive(1'b1, bcast(13'h007F), 5'h1F);
      drive(1'b1, bcast(13'h000F), 5'h1F);
      drive(1'b1, bcast(13'h007F), 5'h1F);

      // Both edge types: 00 -> 55 -> 2A.
      drive(1'b1, bcast(13'h0000), 5'h1F);
      drive(1'b1, bcast(13'h0055), 5'h1F);
      drive(1'b1, bcast(13'h002A), 5'h1F);

      // vld-gated hold on u3 (vld is ignored by the other instances).
      drive(1'b1, bcast(13'h0000), 5'h1F);
      drive(1'b1, bcast(13'h0001), 5'b00111);
      drive(1'b1, bcast(13'h0001), 5'b00111);
      drive(1'b1, bcast(13'h0001), 5'h1F);

      // Reset lands on a pending rising edge; next sample compares to INIT.
      drive(1'b1, bcast(13'h0000), 5'h1F);
      drive(1'b0, bcast(13'h1FFF), 5'h1F);
      drive(1'b1, bcast(13'h1FFF), 5'h1F);
      drive(1'b1, bcast(13'h1FFF), 5'h1F);

      // Randomised traffic with occasional resets, gaps and repeated inputs.
      ins = bcast(13'h1FFF);
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(31) != 0);
         for (int d = 0; d < N; d++) begin
            if ($urandom_range(3) != 0) ins[d] = 13'($urandom);
            v[d] = ($urandom_range(3) != 0);
         end
         drive(r, ins, v);
      end

      // Let the monitor drain the queue.
      repeat (3) @(posedge clk);
      #3;
      stim_done = 1'b1;
      check("drain", 0, 13'(sb_q.size()), 13'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #200000;
      if (!stim_done) begin
         $display("FAIL timeout: stimulus did not complete, got %0d checks", checks);
         $fatal(1, "timeout");
      end
   end

endmodule
